// File: rtl/membus_core_slave.sv
// Core memory slave: 32K x 36 array behind a request/ack/restart memory bus handshake.
// Latency: addr_ack one cycle after an accepted request, rd_rs RD_DLY+1 cycles after addr_ack.
// Backpressure: a write waits in WAITWR for wr_rs; a held rq_cyc parks the FSM in DONE until released.
module membus_core_slave #(
  parameter logic [3:0] MEMSEL = 4'b0000,
  parameter int         RD_DLY = 4,
  parameter int         WR_DLY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_rs,
  input  logic         rq_cyc,
  input  logic         rd_rq,
  input  logic         wr_rq,
  input  logic [21:35] ma,
  input  logic [18:21] sel,
  input  logic         fmc_select,
  input  logic [0:35]  mb_write,
  output logic         addr_ack,
  output logic         rd_rs,
  output logic [0:35]  mb_read
);

  typedef enum logic [2:0] {
    IDLE, ACK, READ, RDRS, WAITWR, WRITE, DONE
  } state_t;

  state_t       state, state_nxt;
  logic [7:0]   dly_cnt;
  logic [21:35] lat_ma;
  logic         lat_rd, lat_wr;
  logic [0:35]  dat_buf;
  logic [0:35]  mem [0:32767];

  logic req_ld, buf_rd_ld, buf_wr_ld, mem_we;
  logic rd_last, wr_last;

  assign rd_last = (dly_cnt == 8'(RD_DLY - 1));
  assign wr_last = (dly_cnt == 8'(WR_DLY - 1));

  // State register; reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode, datapath strobes and bus outputs.
  always_comb begin
    state_nxt = state;
    req_ld    = 1'b0;
    buf_rd_ld = 1'b0;
    buf_wr_ld = 1'b0;
    mem_we    = 1'b0;
    addr_ack  = 1'b0;
    rd_rs     = 1'b0;
    mb_read   = '0;
    case (state)
      IDLE: begin
        if (rq_cyc && !fmc_select && (sel == MEMSEL) && (rd_rq || wr_rq)) begin
          state_nxt = ACK;
          req_ld    = 1'b1;
        end
      end
      ACK: begin
        addr_ack  = 1'b1;
        state_nxt = lat_rd ? READ : WAITWR;
      end
      READ: begin
        if (rd_last) begin
          state_nxt = RDRS;
          buf_rd_ld = 1'b1;
        end
      end
      RDRS: begin
        rd_rs     = 1'b1;
        mb_read   = dat_buf;
        // Read-only cycles restore the destructively read word unchanged.
        state_nxt = lat_wr ? WAITWR : WRITE;
      end
      WAITWR: begin
        // Losing rq_cyc here is the only abort point; nothing has been committed yet.
        if (!rq_cyc) begin
          state_nxt = IDLE;
        end else if (wr_rs) begin
          state_nxt = WRITE;
          buf_wr_ld = 1'b1;
        end
      end
      WRITE: begin
        if (wr_last) begin
          state_nxt = DONE;
          mem_we    = 1'b1;
        end
      end
      DONE: begin
        // Wait for the master to drop rq_cyc so one request is serviced once.
        if (!rq_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, data buffer and the shared READ/WRITE delay counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_cnt <= '0;
      lat_ma  <= '0;
      lat_rd  <= 1'b0;
      lat_wr  <= 1'b0;
      dat_buf <= '0;
    end else begin
      if (state_nxt != state)                   dly_cnt <= '0;
      else if (state == READ || state == WRITE) dly_cnt <= dly_cnt + 8'd1;
      if (req_ld) begin
        lat_ma <= ma;
        lat_rd <= rd_rq;
        lat_wr <= wr_rq;
      end
      if (buf_rd_ld)      dat_buf <= mem[lat_ma];
      else if (buf_wr_ld) dat_buf <= mb_write;
    end
  end

  // Core array: no reset, written only on the last WRITE cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_ma] <= dat_buf;
  end

endmodule

// File: tb/tb_membus_core_slave.sv
module tb_membus_core_slave;

  localparam logic [3:0] MEMSEL = 4'b0000;
  localparam int         RD_DLY = 4;
  localparam int         WR_DLY = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_rs, rq_cyc, rd_rq, wr_rq, fmc_select;
  logic [21:35] ma;
  logic [18:21] sel;
  logic [0:35]  mb_write;
  logic         addr_ack, rd_rs;
  logic [0:35]  mb_read;

  int n_checks = 0;
  int n_errs   = 0;

  membus_core_slave #(.MEMSEL(MEMSEL), .RD_DLY(RD_DLY), .WR_DLY(WR_DLY)) dut (
    .clk(clk), .reset(reset), .wr_rs(wr_rs), .rq_cyc(rq_cyc), .rd_rq(rd_rq),
    .wr_rq(wr_rq), .ma(ma), .sel(sel), .fmc_select(fmc_select),
    .mb_write(mb_write), .addr_ack(addr_ack), .rd_rs(rd_rs), .mb_read(mb_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %o, expected %o", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b0;
    fmc_select = 1'b0; sel = MEMSEL; mb_write = '0;
  endtask

  // Write-only cycle: ACK at k=1, WAITWR k=2, WRITE k=3..6, DONE k=7.
  task automatic do_write(input logic [14:0] a, input logic [35:0] d);
    rq_cyc = 1'b1; wr_rq = 1'b1; rd_rq = 1'b0; ma = a; sel = MEMSEL;
    tick(); check("wr_ack", {35'd0, addr_ack}, 36'd1);
    tick(); check("wr_waitwr_ack", {35'd0, addr_ack}, 36'd0);
    wr_rs = 1'b1; mb_write = d;
    for (int k = 3; k <= 7; k++) begin
      tick();
      wr_rs = 1'b0; mb_write = '0;
      check("wr_no_rd_rs", {35'd0, rd_rs}, 36'd0);
    end
    idle_bus();
    tick();
  endtask

  // Read cycle: ACK k=1, READ k=2..5, RDRS k=6, restore k=7..10, DONE k=11.
  // With noisy=1, bus fields change after ACK and wr_rs carries junk throughout.
  task automatic do_read(input logic [14:0] a, input logic [35:0] exp, input bit noisy);
    rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b0; ma = a; sel = MEMSEL;
    if (noisy) begin wr_rs = 1'b1; mb_write = 36'o525252525252; end
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rd_ack", {35'd0, addr_ack}, (k == 1) ? 36'd1 : 36'd0);
      check("rd_rs", {35'd0, rd_rs}, (k == 2 + RD_DLY) ? 36'd1 : 36'd0);
      check("rd_data", mb_read, (k == 2 + RD_DLY) ? exp : 36'd0);
      if (noisy && k == 1) begin
        ma = ~a; sel = ~MEMSEL; rd_rq = 1'b0; wr_rq = 1'b1;
      end
    end
    idle_bus();
    tick();
  endtask

  // Request that must not be accepted: outputs stay quiet for 8 cycles.
  task automatic do_ignored(input logic [3:0] s, input logic fmc, input logic rd, input logic wr);
    rq_cyc = 1'b1; sel = s; fmc_select = fmc; rd_rq = rd; wr_rq = wr; ma = 15'o00100;
    wr_rs = 1'b1; mb_write = 36'o111111111111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("ign_ack", {35'd0, addr_ack}, 36'd0);
      check("ign_rd_rs", {35'd0, rd_rs}, 36'd0);
      check("ign_data", mb_read, 36'd0);
    end
    idle_bus();
    tick();
  endtask

  initial begin
    reset = 1'b0; ma = '0;
    idle_bus();
    tick(); tick();
    check("rst_ack", {35'd0, addr_ack}, 36'd0);
    check("rst_rd_rs", {35'd0, rd_rs}, 36'd0);
    check("rst_data", mb_read, 36'd0);
    reset = 1'b1;
    tick();

    // Basic write then read, including restore of the read word.
    do_write(15'o00100, 36'o123456701234);
    do_read(15'o00100, 36'o123456701234, 1'b1);
    do_read(15'o00100, 36'o123456701234, 1'b0);

    // Top address, all ones.
    do_write(15'o77777, 36'o777777777777);
    do_read(15'o77777, 36'o777777777777, 1'b0);

    // Read-modify-write of ma=5, rq_cyc held well into DONE.
    do_write(15'o00005, 36'o7);
    rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1; ma = 15'o00005; sel = MEMSEL;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("rmw_ack", {35'd0, addr_ack}, (k == 1) ? 36'd1 : 36'd0);
      check("rmw_rd_rs", {35'd0, rd_rs}, (k == 6) ? 36'd1 : 36'd0);
      check("rmw_data", mb_read, (k == 6) ? 36'o7 : 36'd0);
      if (k == 7) begin wr_rs = 1'b1; mb_write = 36'o10; end
      if (k == 8) begin wr_rs = 1'b0; mb_write = '0; end
    end
    idle_bus();
    tick();
    do_read(15'o00005, 36'o10, 1'b0);

    // Requests that must be ignored; 0o00100 must keep its value.
    do_ignored(4'b0001, 1'b0, 1'b1, 1'b1);
    do_ignored(MEMSEL, 1'b1, 1'b1, 1'b1);
    do_ignored(MEMSEL, 1'b0, 1'b0, 1'b0);
    do_read(15'o00100, 36'o123456701234, 1'b0);

    // Abort in WAITWR: no commit, stray wr_rs in IDLE ignored.
    do_write(15'o00003, 36'o333);
    rq_cyc = 1'b1; wr_rq = 1'b1; rd_rq = 1'b0; ma = 15'o00003; sel = MEMSEL;
    tick(); check("abort_ack", {35'd0, addr_ack}, 36'd1);
    tick();
    rq_cyc = 1'b0; wr_rq = 1'b0;
    tick(); check("abort_no_ack", {35'd0, addr_ack}, 36'd0);
    wr_rs = 1'b1; mb_write = 36'o666;
    tick(); tick();
    idle_bus();
    do_read(15'o00003, 36'o333, 1'b0);

    // Reset in the middle of WRITE: nothing committed.
    rq_cyc = 1'b1; wr_rq = 1'b1; rd_rq = 1'b0; ma = 15'o00003; sel = MEMSEL;
    tick(); check("rstw_ack", {35'd0, addr_ack}, 36'd1);
    tick();
    wr_rs = 1'b1; mb_write = 36'o444;
    tick();
    wr_rs = 1'b0; mb_write = '0;
    tick();
    reset = 1'b0;
    #1;
    check("rstw_ack0", {35'd0, addr_ack}, 36'd0);
    check("rstw_rd_rs0", {35'd0, rd_rs}, 36'd0);
    check("rstw_data0", mb_read, 36'd0);
    // A read request is already on the bus while reset is held.
    wr_rq = 1'b0; rd_rq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_hold_ack", {35'd0, addr_ack}, 36'd0);
    end
    reset = 1'b1;
    do_read(15'o00003, 36'o333, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
